// File: rtl/core_pkg.sv
// Shared types and constants for the memory-access stage.
package core_pkg;

    typedef enum logic [2:0] {
        MemB  = 3'b000,
        MemH  = 3'b001,
        MemW  = 3'b010,
        MemBu = 3'b100,
        MemHu = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2,
        StHold = 2'd3
    } mem_state_t;

    localparam logic [31:0] EXC_LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] EXC_STORE_MISALIGN = 32'd6;

    // size is funct3[1:0]: 00 byte, 01 half, 1x word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/core_mem_lsu_align.sv
// Byte-lane steering: store data replication and byte enables, load lane extract and extend.
module core_mem_lsu_align
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_addr_lo,
    input  logic [31:0]     st_data,
    output logic [31:0]     st_wdata,
    output logic [3:0]      st_byteenable,
    input  mem_op_t         ld_op,
    input  logic [1:0]      ld_addr_lo,
    input  logic [31:0]     ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [15:0] lane;

    always_comb begin
        st_wdata      = st_data;
        st_byteenable = 4'b1111;
        case (st_size)
            2'b00: begin
                st_wdata      = {4{st_data[7:0]}};
                st_byteenable = 4'b0001 << st_addr_lo;
            end
            2'b01: begin
                st_wdata      = {2{st_data[15:0]}};
                st_byteenable = 4'b0011 << st_addr_lo;
            end
            default: ;
        endcase
    end

    assign lane = 16'(ld_rdata >> {ld_addr_lo, 3'b000});

    // Size casts of signed operands sign-extend; unsigned ones zero-extend.
    always_comb begin
        ld_data = XLEN'($signed(ld_rdata));
        case (ld_op)
            MemB:    ld_data = XLEN'($signed(lane[7:0]));
            MemBu:   ld_data = XLEN'(lane[7:0]);
            MemH:    ld_data = XLEN'($signed(lane));
            MemHu:   ld_data = XLEN'(lane);
            default: ;
        endcase
    end

endmodule

// File: rtl/core_mem.sv
// Memory-access pipeline stage: one outstanding bus transaction, misalignment traps,
// pass-through of ALU/CSR results into the MEM/WB register.
module core_mem
    import core_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          ALIGN_CHK = 1'b1
) (
    input  logic            clk,
    input  logic            rest,
    input  logic            em_valid,
    output logic            em_ready,
    input  logic [XLEN-1:0] em_reg_data_mem_addr,
    input  logic [XLEN-1:0] em_csr_data_mem_data,
    input  logic            em_mem_read,
    input  logic            em_mem_write,
    input  logic [2:0]      em_mem_op_type,
    input  logic [4:0]      em_rd,
    input  logic            em_reg_write,
    input  logic [11:0]     em_csr,
    input  logic            em_csr_write,
    input  logic            flush_en,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_read,
    output logic            bus_write,
    output logic [31:0]     bus_wdata,
    output logic [3:0]      bus_byteenable,
    input  logic            bus_waitrequest,
    input  logic [31:0]     bus_rdata,
    input  logic            bus_rdatavalid,
    output logic            mw_valid,
    input  logic            mw_ready,
    output logic [XLEN-1:0] mw_reg_data,
    output logic [4:0]      mw_rd,
    output logic            mw_reg_write,
    output logic [11:0]     mw_csr,
    output logic [XLEN-1:0] mw_csr_data,
    output logic            mw_csr_write,
    output logic            mem_exc_valid,
    output logic [31:0]     mem_exc_cause,
    output logic [XLEN-1:0] mem_exc_addr
);

    mem_state_t      state;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_data;
    mem_op_t         lat_op;
    logic            lat_store;
    logic [4:0]      lat_rd;
    logic            lat_reg_write;
    logic [11:0]     lat_csr;
    logic            lat_csr_write;
    logic            flushed;

    logic            is_mem;
    logic            is_store;
    logic            misaligned;
    logic            accept;
    logic            finish;
    logic            drop;
    logic [31:0]     st_wdata;
    logic [3:0]      st_be;
    logic [XLEN-1:0] ld_data;

    assign is_mem     = em_mem_read | em_mem_write;
    assign is_store   = em_mem_write;
    assign misaligned = ALIGN_CHK &&
                        is_misaligned(em_mem_op_type[1:0], em_reg_data_mem_addr[1:0]);

    assign em_ready = !flush_en &&
                      (((state == StIdle) && (!mw_valid || mw_ready)) ||
                       ((state == StHold) && mw_ready));
    assign accept   = em_valid && em_ready;

    // A bus transaction ends when the store is taken or the load data arrives.
    assign finish = ((state == StReq) && !bus_waitrequest && (lat_store || bus_rdatavalid)) ||
                    ((state == StResp) && bus_rdatavalid);
    assign drop   = flushed || flush_en;

    core_mem_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_size       (em_mem_op_type[1:0]),
        .st_addr_lo    (em_reg_data_mem_addr[1:0]),
        .st_data       (em_csr_data_mem_data[31:0]),
        .st_wdata      (st_wdata),
        .st_byteenable (st_be),
        .ld_op         (lat_op),
        .ld_addr_lo    (lat_addr[1:0]),
        .ld_rdata      (bus_rdata),
        .ld_data       (ld_data)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state          <= StIdle;
            lat_addr       <= '0;
            lat_data       <= '0;
            lat_op         <= MemB;
            lat_store      <= 1'b0;
            lat_rd         <= '0;
            lat_reg_write  <= 1'b0;
            lat_csr        <= '0;
            lat_csr_write  <= 1'b0;
            flushed        <= 1'b0;
            bus_addr       <= '0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_wdata      <= '0;
            bus_byteenable <= '0;
            mw_valid       <= 1'b0;
            mw_reg_data    <= '0;
            mw_rd          <= '0;
            mw_reg_write   <= 1'b0;
            mw_csr         <= '0;
            mw_csr_data    <= '0;
            mw_csr_write   <= 1'b0;
            mem_exc_valid  <= 1'b0;
            mem_exc_cause  <= '0;
            mem_exc_addr   <= '0;
        end else begin
            mem_exc_valid <= 1'b0;
            case (state)
                StIdle, StHold: begin
                    if (mw_ready || flush_en) begin
                        mw_valid <= 1'b0;
                        state    <= StIdle;
                    end
                    if (accept) begin
                        lat_addr      <= em_reg_data_mem_addr;
                        lat_data      <= em_csr_data_mem_data;
                        lat_op        <= mem_op_t'(em_mem_op_type);
                        lat_store     <= is_store;
                        lat_rd        <= em_rd;
                        lat_reg_write <= em_reg_write;
                        lat_csr       <= em_csr;
                        lat_csr_write <= em_csr_write;
                        if (!is_mem) begin
                            mw_valid     <= 1'b1;
                            mw_reg_data  <= em_reg_data_mem_addr;
                            mw_rd        <= em_rd;
                            mw_reg_write <= em_reg_write;
                            mw_csr       <= em_csr;
                            mw_csr_data  <= em_csr_data_mem_data;
                            mw_csr_write <= em_csr_write;
                            state        <= StIdle;
                        end else if (misaligned) begin
                            mem_exc_valid <= 1'b1;
                            mem_exc_cause <= is_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
                            mem_exc_addr  <= em_reg_data_mem_addr;
                            state         <= StIdle;
                        end else begin
                            bus_addr       <= {em_reg_data_mem_addr[XLEN-1:2], 2'b00};
                            bus_read       <= !is_store;
                            bus_write      <= is_store;
                            bus_wdata      <= st_wdata;
                            bus_byteenable <= st_be;
                            flushed        <= 1'b0;
                            state          <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (flush_en) begin
                        flushed <= 1'b1;
                    end
                    if (!bus_waitrequest) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        if (!lat_store && !bus_rdatavalid) begin
                            state <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (flush_en) begin
                        flushed <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase

            if (finish) begin
                if (!drop) begin
                    mw_valid     <= 1'b1;
                    mw_reg_data  <= lat_store ? lat_addr : ld_data;
                    mw_rd        <= lat_rd;
                    mw_reg_write <= lat_reg_write && !lat_store;
                    mw_csr       <= lat_csr;
                    mw_csr_data  <= lat_data;
                    mw_csr_write <= lat_csr_write;
                    state        <= StHold;
                end else begin
                    state <= StIdle;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_mem.sv
// Scoreboard bench for core_mem: directed loads/stores/ALU ops, a scripted bus slave,
// and a monitor that checks every MEM/WB transfer and exception pulse.
module tb_core_mem;

    logic        clk;
    logic        rest;
    logic        em_valid;
    logic        em_ready;
    logic [31:0] em_reg_data_mem_addr;
    logic [31:0] em_csr_data_mem_data;
    logic        em_mem_read;
    logic        em_mem_write;
    logic [2:0]  em_mem_op_type;
    logic [4:0]  em_rd;
    logic        em_reg_write;
    logic [11:0] em_csr;
    logic        em_csr_write;
    logic        flush_en;
    logic [31:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic [31:0] bus_rdata;
    logic        bus_rdatavalid;
    logic        mw_valid;
    logic        mw_ready;
    logic [31:0] mw_reg_data;
    logic [4:0]  mw_rd;
    logic        mw_reg_write;
    logic [11:0] mw_csr;
    logic [31:0] mw_csr_data;
    logic        mw_csr_write;
    logic        mem_exc_valid;
    logic [31:0] mem_exc_cause;
    logic [31:0] mem_exc_addr;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic [11:0] csr;
        logic [31:0] csr_data;
        logic        cw;
        logic        chk_data;
    } mw_t;

    mw_t         mw_q[$];
    logic [63:0] exc_q[$];
    int          tests;
    int          fails;
    int          req_cycles;
    int          mw_cycles;

    // Bus slave script and expected request contents.
    int          ws;
    int          rd_lat;
    logic [31:0] rd_val;
    logic        exp_rd;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        toggle;

    core_mem #(
        .XLEN      (32),
        .ALIGN_CHK (1'b1)
    ) dut (
        .clk                  (clk),
        .rest                 (rest),
        .em_valid             (em_valid),
        .em_ready             (em_ready),
        .em_reg_data_mem_addr (em_reg_data_mem_addr),
        .em_csr_data_mem_data (em_csr_data_mem_data),
        .em_mem_read          (em_mem_read),
        .em_mem_write         (em_mem_write),
        .em_mem_op_type       (em_mem_op_type),
        .em_rd                (em_rd),
        .em_reg_write         (em_reg_write),
        .em_csr               (em_csr),
        .em_csr_write         (em_csr_write),
        .flush_en             (flush_en),
        .bus_addr             (bus_addr),
        .bus_read             (bus_read),
        .bus_write            (bus_write),
        .bus_wdata            (bus_wdata),
        .bus_byteenable       (bus_byteenable),
        .bus_waitrequest      (bus_waitrequest),
        .bus_rdata            (bus_rdata),
        .bus_rdatavalid       (bus_rdatavalid),
        .mw_valid             (mw_valid),
        .mw_ready             (mw_ready),
        .mw_reg_data          (mw_reg_data),
        .mw_rd                (mw_rd),
        .mw_reg_write         (mw_reg_write),
        .mw_csr               (mw_csr),
        .mw_csr_data          (mw_csr_data),
        .mw_csr_write         (mw_csr_write),
        .mem_exc_valid        (mem_exc_valid),
        .mem_exc_cause        (mem_exc_cause),
        .mem_exc_addr         (mem_exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_bus(input string name);
        check(name,
              {bus_read, bus_write, bus_byteenable, bus_addr, exp_rd ? 32'h0 : bus_wdata},
              {exp_rd, !exp_rd, exp_be, exp_addr, exp_rd ? 32'h0 : exp_wdata});
    endfunction

    function automatic void push_mw(input logic [31:0] data, input logic [4:0] rd,
                                    input logic rw, input logic [11:0] csr,
                                    input logic [31:0] csr_data, input logic cw,
                                    input logic chk_data);
        mw_t e;
        e.data     = data;
        e.rd       = rd;
        e.rw       = rw;
        e.csr      = csr;
        e.csr_data = csr_data;
        e.cw       = cw;
        e.chk_data = chk_data;
        mw_q.push_back(e);
    endfunction

    // Monitor: every MEM/WB handshake and exception pulse is matched against the queues.
    initial begin
        req_cycles = 0;
        mw_cycles  = 0;
        forever begin
            @(negedge clk);
            if (bus_read || bus_write) req_cycles++;
            if (mw_valid) mw_cycles++;
            if (rest && mw_valid && mw_ready) begin
                if (mw_q.size() == 0) begin
                    check("mw_unexpected", {mw_reg_data, mw_rd}, 128'h0);
                end else begin
                    mw_t e;
                    e = mw_q.pop_front();
                    check("mw_entry",
                          {e.chk_data ? mw_reg_data : 32'h0, mw_rd, mw_reg_write, mw_csr,
                           mw_csr_data, mw_csr_write},
                          {e.chk_data ? e.data : 32'h0, e.rd, e.rw, e.csr, e.csr_data, e.cw});
                end
            end
            if (rest && mem_exc_valid) begin
                if (exc_q.size() == 0) begin
                    check("exc_unexpected", {mem_exc_cause, mem_exc_addr}, 128'h0);
                end else begin
                    logic [63:0] x;
                    x = exc_q.pop_front();
                    check("exc_entry", {mem_exc_cause, mem_exc_addr}, x);
                end
            end
        end
    end

    // Scripted bus slave; request contents must hold while waitrequest is asserted.
    initial begin
        logic is_rd;
        logic aborted;
        bus_waitrequest = 1'b0;
        bus_rdatavalid  = 1'b0;
        bus_rdata       = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rest && (bus_read || bus_write)) begin
                is_rd   = bus_read;
                aborted = 1'b0;
                check_bus("bus_req");
                for (int i = 0; i < ws; i++) begin
                    bus_waitrequest = 1'b1;
                    @(posedge clk); #1;
                    if (!rest) aborted = 1'b1;
                    if (!aborted) check_bus("bus_hold");
                end
                bus_waitrequest = 1'b0;
                if (is_rd) begin
                    bus_rdata = rd_val;
                    if (rd_lat == 0) bus_rdatavalid = 1'b1;
                    @(posedge clk); #1;
                    bus_rdatavalid = 1'b0;
                    if (rd_lat > 0) begin
                        for (int i = 1; i < rd_lat; i++) begin
                            @(posedge clk); #1;
                        end
                        bus_rdatavalid = 1'b1;
                        @(posedge clk); #1;
                        bus_rdatavalid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        mw_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            mw_ready = toggle ? ~mw_ready : 1'b1;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic issue(input logic rd_, input logic wr_, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input logic rw, input logic [11:0] csr, input logic cw);
        int n;
        em_valid             = 1'b1;
        em_mem_read          = rd_;
        em_mem_write         = wr_;
        em_mem_op_type       = op;
        em_reg_data_mem_addr = a;
        em_csr_data_mem_data = d;
        em_rd                = rd;
        em_reg_write         = rw;
        em_csr               = csr;
        em_csr_write         = cw;
        n = 0;
        @(negedge clk);
        while (!em_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!em_ready) check("accept_timeout", {31'h0, em_ready}, 128'h1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        em_valid     = 1'b0;
        em_mem_read  = 1'b0;
        em_mem_write = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mw_q.size() != 0 || exc_q.size() != 0 || mw_valid || bus_read || bus_write)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 128'(n), 128'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n;
        tests    = 0;
        fails    = 0;
        toggle   = 1'b0;
        ws       = 0;
        rd_lat   = 0;
        rd_val   = 32'h0;
        exp_rd   = 1'b1;
        exp_addr = 32'h0;
        exp_wdata = 32'h0;
        exp_be   = 4'h0;
        rest     = 1'b0;
        flush_en = 1'b0;
        em_reg_data_mem_addr = 32'h0;
        em_csr_data_mem_data = 32'h0;
        em_mem_op_type = 3'b000;
        em_rd = 5'd0;
        em_reg_write = 1'b0;
        em_csr = 12'h0;
        em_csr_write = 1'b0;
        idle();

        repeat (3) @(negedge clk);
        check("reset_outputs_zero",
              {127'h0, |{bus_read, bus_write, bus_addr, bus_wdata, bus_byteenable, mw_valid,
                         mw_reg_data, mw_rd, mw_reg_write, mw_csr, mw_csr_data, mw_csr_write,
                         mem_exc_valid, mem_exc_cause, mem_exc_addr}}, 128'h0);
        rest = 1'b1;
        @(negedge clk);
        check("reset_em_ready", {127'h0, em_ready}, 128'h1);
        @(posedge clk); #1;

        // LW 0x100, data two cycles after the request is taken.
        ws = 0; rd_lat = 2; rd_val = 32'hDEADBEEF;
        exp_rd = 1'b1; exp_addr = 32'h100; exp_be = 4'b1111;
        push_mw(32'hDEADBEEF, 5'd5, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 12'h0, 1'b0);
        idle();
        n = 0;
        @(negedge clk);
        while (!bus_rdatavalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lw_mw_before_rdv", {126'h0, bus_rdatavalid, mw_valid}, {126'h0, 2'b10});
        @(negedge clk);
        check("lw_mw_after_rdv", {127'h0, mw_valid}, 128'h1);
        drain();

        // Sub-word loads from rdata 0x80123456.
        rd_val = 32'h80123456;
        ws = 0; rd_lat = 1; exp_addr = 32'h100; exp_be = 4'b1000;
        push_mw(32'hFFFFFF80, 5'd6, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1'b1, 12'h0, 1'b0);
        idle();
        drain();
        rd_lat = 0;
        push_mw(32'h00000080, 5'd7, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1, 12'h0, 1'b0);
        idle();
        drain();
        rd_lat = 1; exp_be = 4'b1100;
        push_mw(32'hFFFF8012, 5'd8, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd8, 1'b1, 12'h0, 1'b0);
        idle();
        drain();
        push_mw(32'h00008012, 5'd9, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 1'b1, 12'h0, 1'b0);
        idle();
        drain();

        // Stores: SH with three wait cycles, SB at lane 1; rd write is suppressed.
        ws = 3; exp_rd = 1'b0; exp_addr = 32'h100; exp_be = 4'b1100;
        exp_wdata = 32'h12341234;
        push_mw(32'h0, 5'd10, 1'b0, 12'h0, 32'hABCD1234, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'hABCD1234, 5'd10, 1'b1, 12'h0, 1'b0);
        idle();
        drain();
        ws = 1; exp_be = 4'b0010; exp_wdata = 32'hA5A5A5A5;
        push_mw(32'h0, 5'd11, 1'b0, 12'h0, 32'h000000A5, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 3'b000, 32'h101, 32'h000000A5, 5'd11, 1'b1, 12'h0, 1'b0);
        idle();
        drain();

        // Misaligned accesses trap without touching the bus or MEM/WB.
        base = req_cycles;
        n    = mw_cycles;
        exc_q.push_back({32'd4, 32'h101});
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd12, 1'b1, 12'h0, 1'b0);
        idle();
        drain();
        exc_q.push_back({32'd6, 32'h102});
        issue(1'b0, 1'b1, 3'b010, 32'h102, 32'h55, 5'd13, 1'b0, 12'h0, 1'b0);
        idle();
        drain();
        check("misalign_no_bus", 128'(req_cycles - base), 128'h0);
        check("misalign_no_mw", 128'(mw_cycles - n), 128'h0);

        // Back-to-back ALU results against a toggling mw_ready.
        toggle = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_mw(32'h10000000 + i, 5'(i + 1), 1'b1, 12'(12'h300 + i), 32'hC0DE0000 + i,
                    1'(i % 2), 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 1'b0, 3'b000, 32'h10000000 + i, 32'hC0DE0000 + i, 5'(i + 1), 1'b1,
                  12'(12'h300 + i), 1'(i % 2));
        end
        idle();
        drain();
        toggle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Flush while waiting for load data: the response is swallowed.
        ws = 0; rd_lat = 4; rd_val = 32'hCAFEF00D;
        exp_rd = 1'b1; exp_addr = 32'h200; exp_be = 4'b1111;
        base = mw_cycles;
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd14, 1'b1, 12'h0, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        flush_en = 1'b1;
        @(negedge clk);
        flush_en = 1'b0;
        repeat (8) @(negedge clk);
        check("flush_no_mw", 128'(mw_cycles - base), 128'h0);
        @(posedge clk); #1;
        push_mw(32'h0000BEEF, 5'd15, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 3'b000, 32'h0000BEEF, 32'h0, 5'd15, 1'b1, 12'h0, 1'b0);
        idle();
        drain();

        // Reset in the middle of a stalled request; the late response is ignored.
        ws = 8; rd_lat = 1; rd_val = 32'h77777777; exp_addr = 32'h300;
        base = mw_cycles;
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd16, 1'b1, 12'h0, 1'b0);
        idle();
        @(negedge clk);
        rest = 1'b0;
        #1;
        check("async_reset_outputs_zero",
              {127'h0, |{bus_read, bus_write, bus_addr, bus_wdata, bus_byteenable, mw_valid,
                         mw_reg_data, mw_rd, mw_reg_write, mw_csr, mw_csr_data, mw_csr_write,
                         mem_exc_valid, mem_exc_cause, mem_exc_addr}}, 128'h0);
        @(negedge clk);
        rest = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_late_rdv_ignored", 128'(mw_cycles - base), 128'h0);
        @(posedge clk); #1;

        ws = 0; rd_lat = 1; rd_val = 32'h11223344; exp_addr = 32'h104; exp_be = 4'b1111;
        push_mw(32'h11223344, 5'd17, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd17, 1'b1, 12'h0, 1'b0);
        idle();
        drain();

        check("mw_queue_empty", 128'(mw_q.size()), 128'h0);
        check("exc_queue_empty", 128'(exc_q.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
